// File: rtl/axi_sram_responder.sv
// AXI4 responder backed by a word-organised SRAM array; one transaction in flight,
// FIXED/INCR bursts (WRAP treated as INCR), byte strobes and SLVERR for out-of-range beats.
module axi_sram_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          DEPTH_LOG2   = 12,
  parameter int          READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [1:0]  io_slave_rresp,
  output logic [31:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'd4 << DEPTH_LOG2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_LAT  = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  function automatic logic addr_in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a >= BASE_ADDR) && (off < SPAN);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  // Sizes above one word behave as a full word; FIXED keeps the address.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    logic [2:0] s;
    s = (size > 3'd2) ? 3'd2 : size;
    if (burst == 2'b00) begin
      return a;
    end else begin
      return a + (32'd1 << s);
    end
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  len_q, len_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d;
  logic [7:0]  beat_q, beat_d;
  logic [3:0]  lat_q, lat_d;
  logic        err_q, err_d;
  logic        awready_q, awready_d;
  logic        arready_q, arready_d;
  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [3:0]  bid_q, bid_d;
  logic        rvalid_q, rvalid_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rlast_q, rlast_d;
  logic [3:0]  rid_q, rid_d;

  logic [31:0] mem_q [DEPTH];

  logic                  ar_hs_s, aw_hs_s, wr_hs_s, wr_ok_s, mem_we_s, rd_ok_s;
  logic [31:0]           rd_addr_s, rd_word_s;
  logic [DEPTH_LOG2-1:0] wr_idx_s;
  logic                  unused_wlast_s;

  assign unused_wlast_s = io_slave_wlast;

  // Handshake qualifiers; a simultaneous AR masks AW so reads win.
  assign ar_hs_s  = (state_q == IDLE) && arready_q && io_slave_arvalid;
  assign aw_hs_s  = (state_q == IDLE) && awready_q && io_slave_awvalid && !io_slave_arvalid;
  assign wr_hs_s  = (state_q == WR_DATA) && wready_q && io_slave_wvalid;
  assign wr_ok_s  = addr_in_range(addr_q);
  assign wr_idx_s = word_idx(addr_q);
  assign mem_we_s = wr_hs_s && wr_ok_s;

  // Address of the beat that will be presented on R at the next edge.
  always_comb begin
    if (state_q == IDLE) begin
      rd_addr_s = io_slave_araddr;
    end else if (state_q == RD_DATA) begin
      rd_addr_s = next_addr(addr_q, size_q, burst_q);
    end else begin
      rd_addr_s = addr_q;
    end
  end

  assign rd_ok_s   = addr_in_range(rd_addr_s);
  assign rd_word_s = rd_ok_s ? mem_q[word_idx(rd_addr_s)] : 32'd0;

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    id_d      = id_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    err_d     = err_q;
    awready_d = awready_q;
    arready_d = arready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;

    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        awready_d = 1'b1;
        if (ar_hs_s) begin
          addr_d    = io_slave_araddr;
          id_d      = io_slave_arid;
          len_d     = io_slave_arlen;
          size_d    = io_slave_arsize;
          burst_d   = io_slave_arburst;
          beat_d    = 8'd0;
          rid_d     = io_slave_arid;
          arready_d = 1'b0;
          awready_d = 1'b0;
          if (READ_LATENCY <= 1) begin
            state_d  = RD_DATA;
            rvalid_d = 1'b1;
            rdata_d  = rd_word_s;
            rresp_d  = rd_ok_s ? 2'b00 : 2'b10;
            rlast_d  = (io_slave_arlen == 8'd0);
          end else begin
            state_d = RD_LAT;
            lat_d   = 4'(READ_LATENCY - 1);
          end
        end else if (aw_hs_s) begin
          addr_d    = io_slave_awaddr;
          id_d      = io_slave_awid;
          len_d     = io_slave_awlen;
          size_d    = io_slave_awsize;
          burst_d   = io_slave_awburst;
          beat_d    = 8'd0;
          err_d     = 1'b0;
          arready_d = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = WR_DATA;
        end else begin
          state_d = IDLE;
        end
      end
      RD_LAT: begin
        if (lat_q <= 4'd1) begin
          state_d  = RD_DATA;
          rvalid_d = 1'b1;
          rdata_d  = rd_word_s;
          rresp_d  = rd_ok_s ? 2'b00 : 2'b10;
          rlast_d  = (len_q == 8'd0);
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RD_DATA: begin
        if (rvalid_q && io_slave_rready) begin
          if (rlast_q) begin
            state_d   = IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            awready_d = 1'b1;
          end else begin
            addr_d  = rd_addr_s;
            beat_d  = beat_q + 8'd1;
            rdata_d = rd_word_s;
            rresp_d = rd_ok_s ? 2'b00 : 2'b10;
            rlast_d = ((beat_q + 8'd1) == len_q);
          end
        end else begin
          rvalid_d = rvalid_q;
        end
      end
      WR_DATA: begin
        if (wr_hs_s) begin
          if (beat_q == len_q) begin
            state_d  = WR_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = (err_q || !wr_ok_s) ? 2'b10 : 2'b00;
          end else begin
            addr_d = next_addr(addr_q, size_q, burst_q);
            beat_d = beat_q + 8'd1;
            err_d  = err_q || !wr_ok_s;
          end
        end else begin
          wready_d = wready_q;
        end
      end
      WR_RESP: begin
        if (io_slave_bready) begin
          state_d   = IDLE;
          bvalid_d  = 1'b0;
          arready_d = 1'b1;
          awready_d = 1'b1;
        end else begin
          bvalid_d = bvalid_q;
        end
      end
      default: begin
        state_d   = IDLE;
        awready_d = 1'b0;
        arready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Control and response registers; an asserted reset abandons any burst.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      id_q      <= 4'd0;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
      burst_q   <= 2'd0;
      beat_q    <= 8'd0;
      lat_q     <= 4'd0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= 4'd0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= 32'd0;
      rlast_q   <= 1'b0;
      rid_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      err_q     <= err_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
    end
  end

  // Array storage is never reset; only strobed lanes of in-range beats are written.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave_wstrb[b]) begin
          mem_q[wr_idx_s][8*b +: 8] <= io_slave_wdata[8*b +: 8];
        end
      end
    end
  end

  assign io_slave_awready = awready_q && !io_slave_arvalid;
  assign io_slave_wready  = wready_q;
  assign io_slave_bvalid  = bvalid_q;
  assign io_slave_bresp   = bresp_q;
  assign io_slave_bid     = bid_q;
  assign io_slave_arready = arready_q;
  assign io_slave_rvalid  = rvalid_q;
  assign io_slave_rresp   = rresp_q;
  assign io_slave_rdata   = rdata_q;
  assign io_slave_rlast   = rlast_q;
  assign io_slave_rid     = rid_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed plus randomized bench for axi_sram_responder against a word-array reference model.
module tb_axi_sram_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_slave_awready, io_slave_awvalid = 1'b0;
  logic [31:0] io_slave_awaddr = 32'd0;
  logic [3:0]  io_slave_awid = 4'd0;
  logic [7:0]  io_slave_awlen = 8'd0;
  logic [2:0]  io_slave_awsize = 3'd0;
  logic [1:0]  io_slave_awburst = 2'd0;
  logic        io_slave_wready, io_slave_wvalid = 1'b0;
  logic [31:0] io_slave_wdata = 32'd0;
  logic [3:0]  io_slave_wstrb = 4'd0;
  logic        io_slave_wlast = 1'b0;
  logic        io_slave_bready = 1'b0, io_slave_bvalid;
  logic [1:0]  io_slave_bresp;
  logic [3:0]  io_slave_bid;
  logic        io_slave_arready, io_slave_arvalid = 1'b0;
  logic [31:0] io_slave_araddr = 32'd0;
  logic [3:0]  io_slave_arid = 4'd0;
  logic [7:0]  io_slave_arlen = 8'd0;
  logic [2:0]  io_slave_arsize = 3'd0;
  logic [1:0]  io_slave_arburst = 2'd0;
  logic        io_slave_rready = 1'b0, io_slave_rvalid;
  logic [1:0]  io_slave_rresp;
  logic [31:0] io_slave_rdata;
  logic        io_slave_rlast;
  logic [3:0]  io_slave_rid;

  axi_sram_responder dut (
    .clock(clock), .reset(reset),
    .io_slave_awready(io_slave_awready), .io_slave_awvalid(io_slave_awvalid),
    .io_slave_awaddr(io_slave_awaddr), .io_slave_awid(io_slave_awid),
    .io_slave_awlen(io_slave_awlen), .io_slave_awsize(io_slave_awsize),
    .io_slave_awburst(io_slave_awburst),
    .io_slave_wready(io_slave_wready), .io_slave_wvalid(io_slave_wvalid),
    .io_slave_wdata(io_slave_wdata), .io_slave_wstrb(io_slave_wstrb),
    .io_slave_wlast(io_slave_wlast),
    .io_slave_bready(io_slave_bready), .io_slave_bvalid(io_slave_bvalid),
    .io_slave_bresp(io_slave_bresp), .io_slave_bid(io_slave_bid),
    .io_slave_arready(io_slave_arready), .io_slave_arvalid(io_slave_arvalid),
    .io_slave_araddr(io_slave_araddr), .io_slave_arid(io_slave_arid),
    .io_slave_arlen(io_slave_arlen), .io_slave_arsize(io_slave_arsize),
    .io_slave_arburst(io_slave_arburst),
    .io_slave_rready(io_slave_rready), .io_slave_rvalid(io_slave_rvalid),
    .io_slave_rresp(io_slave_rresp), .io_slave_rdata(io_slave_rdata),
    .io_slave_rlast(io_slave_rlast), .io_slave_rid(io_slave_rid)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: one word per array slot, plus a flag for slots ever written.
  logic [31:0] ref_mem [0:4095];
  bit          ref_known [0:4095];
  logic [31:0] wdat [0:15];
  logic [3:0]  wstb [0:15];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_arr(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8000_4000);
  endfunction

  function automatic int slot(input logic [31:0] a);
    return int'((a - 32'h8000_0000) >> 2);
  endfunction

  // Beat i of a burst in closed form: start + i * bytes-per-beat, modulo 2^32.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i,
                                            input logic [2:0] size, input logic [1:0] burst);
    int unsigned step;
    step = (size > 3'd2) ? 4 : (1 << size);
    if (burst == 2'b00) return a;
    return a + 32'(i * step);
  endfunction

  function automatic bit model_write(input logic [31:0] a, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    bit err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] ba = beat_addr(a, i, size, burst);
      if (in_arr(ba)) begin
        for (int b = 0; b < 4; b++)
          if (wstb[i][b]) ref_mem[slot(ba)][8*b +: 8] = wdat[i][8*b +: 8];
        ref_known[slot(ba)] = 1;
      end else begin
        err = 1;
      end
    end
    return err;
  endfunction

  task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    io_slave_arvalid = 1'b1; io_slave_araddr = a; io_slave_arlen = len;
    io_slave_arsize = size; io_slave_arburst = burst; io_slave_arid = id;
    #1;
    while (io_slave_arready !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
    chk("ar_wait_bound", 32'(n < 100), 32'd1);
    @(posedge clock); #1;
    io_slave_arvalid = 1'b0;
  endtask

  task automatic r_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int mode);
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] ba = beat_addr(a, i, size, burst);
      logic [31:0] held;
      bit stall;
      int n = 0;
      while (io_slave_rvalid !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
      chk("r_beat_latency", 32'(n), 32'd0);
      stall = (mode == 1) ? (i % 2 == 0) : (mode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
      if (stall) begin
        held = io_slave_rdata;
        io_slave_rready = 1'b0;
        @(posedge clock); #1;
        chk("r_stall_valid", 32'(io_slave_rvalid), 32'd1);
        chk("r_stall_data", io_slave_rdata, held);
      end
      io_slave_rready = 1'b1;
      if (!in_arr(ba)) begin
        chk("r_oor_data", io_slave_rdata, 32'd0);
        chk("r_oor_resp", 32'(io_slave_rresp), 32'd2);
      end else begin
        if (ref_known[slot(ba)]) chk("r_data", io_slave_rdata, ref_mem[slot(ba)]);
        chk("r_resp", 32'(io_slave_rresp), 32'd0);
      end
      chk("r_last", 32'(io_slave_rlast), 32'(i == int'(len)));
      chk("r_id", 32'(io_slave_rid), 32'(id));
      @(posedge clock); #1;
      io_slave_rready = 1'b0;
    end
  endtask

  task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int n = 0;
    io_slave_awvalid = 1'b1; io_slave_awaddr = a; io_slave_awlen = len;
    io_slave_awsize = size; io_slave_awburst = burst; io_slave_awid = id;
    #1;
    while (io_slave_awready !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
    chk("aw_wait_bound", 32'(n < 100), 32'd1);
    @(posedge clock); #1;
    io_slave_awvalid = 1'b0;
  endtask

  task automatic w_phase(input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      int n = 0;
      io_slave_wvalid = 1'b1; io_slave_wdata = wdat[i]; io_slave_wstrb = wstb[i];
      io_slave_wlast = (i == int'(len));
      #1;
      while (io_slave_wready !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
      chk("w_wait_bound", 32'(n < 100), 32'd1);
      @(posedge clock); #1;
    end
    io_slave_wvalid = 1'b0; io_slave_wlast = 1'b0;
  endtask

  task automatic b_phase(input logic [1:0] exp_resp, input logic [3:0] id);
    int n = 0;
    io_slave_bready = 1'b1;
    while (io_slave_bvalid !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
    chk("b_wait_bound", 32'(n < 100), 32'd1);
    chk("b_resp", 32'(io_slave_bresp), 32'(exp_resp));
    chk("b_id", 32'(io_slave_bid), 32'(id));
    @(posedge clock); #1;
    io_slave_bready = 1'b0;
    chk("b_dropped", 32'(io_slave_bvalid), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    bit err = model_write(a, len, size, burst);
    aw_phase(a, len, size, burst, id);
    w_phase(len);
    b_phase(err ? 2'b10 : 2'b00, id);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input int mode);
    ar_phase(a, len, size, burst, id);
    r_phase(a, len, size, burst, id, mode);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin ref_mem[i] = 32'd0; ref_known[i] = 0; end
    repeat (2) @(posedge clock);
    #1;
    chk("rst_arready", 32'(io_slave_arready), 32'd0);
    chk("rst_awready", 32'(io_slave_awready), 32'd0);
    chk("rst_wready", 32'(io_slave_wready), 32'd0);
    chk("rst_bvalid", 32'(io_slave_bvalid), 32'd0);
    chk("rst_rvalid", 32'(io_slave_rvalid), 32'd0);
    chk("rst_rlast", 32'(io_slave_rlast), 32'd0);
    chk("rst_rdata", io_slave_rdata, 32'd0);
    chk("rst_resp", {28'd0, io_slave_bresp, io_slave_rresp}, 32'd0);
    chk("rst_ids", {24'd0, io_slave_bid, io_slave_rid}, 32'd0);
    @(negedge clock); reset = 1'b1;

    // Single-beat read of a preloaded word.
    wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
    do_write(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd1);
    do_read(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd3, 0);

    // Four-beat INCR write, read back free-running and with rready toggling.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstb[i] = 4'hF; end
    do_write(32'h8000_0010, 8'd3, 3'd2, 2'b01, 4'd7);
    do_read(32'h8000_0010, 8'd3, 3'd2, 2'b01, 4'd2, 0);
    do_read(32'h8000_0010, 8'd3, 3'd2, 2'b01, 4'd9, 1);

    // Sub-word strobe onto a cleared word.
    wdat[0] = 32'd0; wstb[0] = 4'hF;
    do_write(32'h8000_0020, 8'd0, 3'd2, 2'b01, 4'd0);
    wdat[0] = 32'h1122_3344; wstb[0] = 4'b0100;
    do_write(32'h8000_0020, 8'd0, 3'd0, 2'b01, 4'd0);
    do_read(32'h8000_0020, 8'd0, 3'd2, 2'b01, 4'd1, 0);

    // AR and AW raised together: read first, write after the read completes.
    wdat[0] = 32'hCAFE_F00D; wstb[0] = 4'hF;
    io_slave_awvalid = 1'b1; io_slave_awaddr = 32'h8000_0030; io_slave_awlen = 8'd0;
    io_slave_awsize = 3'd2; io_slave_awburst = 2'b01; io_slave_awid = 4'd4;
    io_slave_arvalid = 1'b1; io_slave_araddr = 32'h8000_0010; io_slave_arlen = 8'd0;
    io_slave_arsize = 3'd2; io_slave_arburst = 2'b01; io_slave_arid = 4'd6;
    #1;
    chk("both_arready", 32'(io_slave_arready), 32'd1);
    chk("both_awready", 32'(io_slave_awready), 32'd0);
    @(posedge clock); #1;
    io_slave_arvalid = 1'b0;
    chk("both_aw_held_off", 32'(io_slave_awready), 32'd0);
    r_phase(32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'd6, 0);
    void'(model_write(32'h8000_0030, 8'd0, 3'd2, 2'b01));
    aw_phase(32'h8000_0030, 8'd0, 3'd2, 2'b01, 4'd4);
    w_phase(8'd0);
    b_phase(2'b00, 4'd4);
    do_read(32'h8000_0030, 8'd0, 3'd2, 2'b01, 4'd4, 0);

    // Out-of-range read, and a write straddling the top of the array.
    do_read(32'h0000_0000, 8'd0, 3'd2, 2'b01, 4'd5, 0);
    wdat[0] = 32'h0BAD_F00D; wdat[1] = 32'h1234_5678; wstb[0] = 4'hF; wstb[1] = 4'hF;
    do_write(32'h8000_3FFC, 8'd1, 3'd2, 2'b01, 4'd8);
    do_read(32'h8000_3FFC, 8'd1, 3'd2, 2'b01, 4'd8, 0);

    // Reset asserted while beat 2 of an 8-beat read is being presented.
    ar_phase(32'h8000_0010, 8'd7, 3'd2, 2'b01, 4'd5);
    io_slave_rready = 1'b1;
    @(posedge clock); #1;
    io_slave_rready = 1'b0;
    chk("mid_beat2_valid", 32'(io_slave_rvalid), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(io_slave_rvalid), 32'd0);
    chk("mid_rst_rlast", 32'(io_slave_rlast), 32'd0);
    @(negedge clock); reset = 1'b1;
    do_read(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd3, 0);

    // Randomized bursts, each written then read back with random stalls.
    for (int t = 0; t < 24; t++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  id;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_3FF0 + 32'($urandom_range(0, 15));
      else a = 32'h8000_0100 + 32'($urandom_range(0, 255));
      len = 8'($urandom_range(0, 7));
      size = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 2));
      id = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
      do_write(a, len, size, burst, id);
      do_read(a, len, size, burst, 4'(~id), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
